// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and fault codes for the vend dispenser
package vend_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PROD_DRIVE,
        S_PROD_WAIT,
        S_COIN_CHK,
        S_COIN_DRIVE,
        S_COIN_WAIT,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_PROD  = 2'b01;
    localparam logic [1:0] FLT_COIN  = 2'b10;
    localparam logic [1:0] FLT_EMPTY = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vend_dispenser_timer.sv
// rtl/vend_dispenser_timer.sv - shared down-counter reused for every timed state
module dispense_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= load_val;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - pays out a vend request: product solenoid, then coin ejections
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYC  = 4,
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYC    = 2,
    parameter int COIN_CAP   = 50,
    parameter int CNT_W      = 8,
    parameter int LOW_THRESH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vend,
    input  logic [1:0]       change,
    input  logic             prod_sense,
    input  logic             coin_sense,
    input  logic             refill,
    input  logic             clr_fault,
    output logic             prod_drive,
    output logic             coin_drive,
    output logic             busy,
    output logic             done,
    output logic             req_drop,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] coin_count,
    output logic             coin_low
);

    localparam int TMR_W = $clog2(max3(PULSE_CYC, TIMEOUT, GAP_CYC) + 1);

    state_t             state, state_nxt;
    logic [1:0]         coins_left;
    logic [1:0]         code_q;
    logic [CNT_W-1:0]   count_q;
    logic               req;
    logic               coin_dec;
    logic               flt_set;
    logic [1:0]         flt_new;
    logic               tmr_start;
    logic               tmr_exp;
    logic [TMR_W-1:0]   tmr_load;

    assign req = vend || (change != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        coin_dec  = 1'b0;
        flt_set   = 1'b0;
        flt_new   = FLT_NONE;
        case (state)
            S_IDLE: begin
                if (vend) begin
                    state_nxt = S_PROD_DRIVE;
                end else if (change != 2'd0) begin
                    // change-only requests still honour the empty-tube guard
                    if (count_q == '0) begin
                        state_nxt = S_FAULT;
                        flt_set   = 1'b1;
                        flt_new   = FLT_EMPTY;
                    end else begin
                        state_nxt = S_COIN_DRIVE;
                    end
                end
            end
            S_PROD_DRIVE: if (tmr_exp) state_nxt = S_PROD_WAIT;
            S_PROD_WAIT: begin
                if (prod_sense) begin
                    state_nxt = (coins_left != 2'd0) ? S_COIN_CHK : S_DONE;
                end else if (tmr_exp) begin
                    state_nxt = S_FAULT;
                    flt_set   = 1'b1;
                    flt_new   = FLT_PROD;
                end
            end
            S_COIN_CHK: begin
                if (count_q == '0) begin
                    state_nxt = S_FAULT;
                    flt_set   = 1'b1;
                    flt_new   = FLT_EMPTY;
                end else begin
                    state_nxt = S_COIN_DRIVE;
                end
            end
            S_COIN_DRIVE: if (tmr_exp) state_nxt = S_COIN_WAIT;
            S_COIN_WAIT: begin
                if (coin_sense) begin
                    coin_dec  = 1'b1;
                    state_nxt = (coins_left > 2'd1) ? S_GAP : S_DONE;
                end else if (tmr_exp) begin
                    state_nxt = S_FAULT;
                    flt_set   = 1'b1;
                    flt_new   = FLT_COIN;
                end
            end
            S_GAP:   if (tmr_exp) state_nxt = S_COIN_CHK;
            S_DONE:  state_nxt = S_IDLE;
            S_FAULT: if (clr_fault) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timer holds duration-1 so that expiry lands on the last cycle of the state
    always_comb begin
        tmr_load = '0;
        case (state_nxt)
            S_PROD_DRIVE, S_COIN_DRIVE: tmr_load = TMR_W'(PULSE_CYC - 1);
            S_PROD_WAIT, S_COIN_WAIT:   tmr_load = TMR_W'(TIMEOUT - 1);
            S_GAP:                      tmr_load = TMR_W'(GAP_CYC - 1);
            default:                    tmr_load = '0;
        endcase
    end

    assign tmr_start = (state_nxt != state);

    dispense_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (tmr_start),
        .load_val (tmr_load),
        .tick     (1'b1),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            coins_left <= 2'd0;
            code_q     <= FLT_NONE;
            count_q    <= CNT_W'(COIN_CAP);
        end else begin
            if (state == S_IDLE && req) begin
                coins_left <= change;
            end else if (coin_dec) begin
                coins_left <= coins_left - 2'd1;
            end

            if (flt_set) begin
                code_q <= flt_new;
            end else if (state == S_FAULT && clr_fault) begin
                code_q <= FLT_NONE;
            end

            if (coin_dec) begin
                count_q <= count_q - CNT_W'(1);
            end else if (refill && (state == S_IDLE || state == S_FAULT)) begin
                count_q <= CNT_W'(COIN_CAP);
            end
        end
    end

    assign prod_drive = (state == S_PROD_DRIVE);
    assign coin_drive = (state == S_COIN_DRIVE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign req_drop   = (state != S_IDLE) && req;
    assign fault      = (state == S_FAULT);
    assign fault_code = code_q;
    assign coin_count = count_q;
    assign coin_low   = (count_q < CNT_W'(LOW_THRESH));

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - randomized and directed checks against a transaction-level payout model
module tb_vend_dispenser;

    localparam int PULSE_CYC  = 4;
    localparam int TIMEOUT    = 16;
    localparam int GAP_CYC    = 2;
    localparam int COIN_CAP   = 50;
    localparam int LOW_THRESH = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vend = 1'b0;
    logic [1:0] change = 2'd0;
    logic       prod_sense = 1'b0;
    logic       coin_sense = 1'b0;
    logic       refill = 1'b0;
    logic       clr_fault = 1'b0;
    logic       prod_drive, coin_drive, busy, done, req_drop, fault, coin_low;
    logic [1:0] fault_code;
    logic [7:0] coin_count;

    vend_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .vend       (vend),
        .change     (change),
        .prod_sense (prod_sense),
        .coin_sense (coin_sense),
        .refill     (refill),
        .clr_fault  (clr_fault),
        .prod_drive (prod_drive),
        .coin_drive (coin_drive),
        .busy       (busy),
        .done       (done),
        .req_drop   (req_drop),
        .fault      (fault),
        .fault_code (fault_code),
        .coin_count (coin_count),
        .coin_low   (coin_low)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int model_cnt = COIN_CAP;

    // Sensor environment and pulse monitor state
    int prod_d = 1000, coin_d = 1000;
    int pw_p = -1, pw_c = -1;
    int pd_len = 0, cd_len = 0, cl_len = 0;
    int exp_gap = 0;
    bit have_prev_coin = 0, mon_en = 1;
    bit prev_pd = 0, prev_cd = 0, prev_fault = 0;
    int n_prod = 0, n_coin = 0, n_done = 0, n_drop = 0;
    bit fault_seen = 0;
    int f_pw_p = 0, f_pw_c = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One clock of environment: answers drives with sensor pulses, measures pulses and gaps
    task automatic cycle();
        @(negedge clk);
        if (prod_drive) begin
            if (!prev_pd) n_prod++;
            pd_len++;
            pw_p = -1;
        end else if (prev_pd) begin
            if (mon_en) check("prod_width", pd_len, PULSE_CYC);
            pd_len = 0;
            pw_p = 0;
        end else if (pw_p >= 0) begin
            pw_p++;
        end
        prod_sense = (pw_p >= 0 && pw_p == prod_d);

        if (coin_drive) begin
            if (!prev_cd) begin
                n_coin++;
                if (have_prev_coin && mon_en) check("coin_gap", cl_len, exp_gap);
            end
            cd_len++;
            pw_c = -1;
        end else if (prev_cd) begin
            if (mon_en) check("coin_width", cd_len, PULSE_CYC);
            cd_len = 0;
            pw_c = 0;
            cl_len = 1;
            have_prev_coin = 1;
        end else begin
            cl_len++;
            if (pw_c >= 0) pw_c++;
        end
        coin_sense = (pw_c >= 0 && pw_c == coin_d);

        if (done) n_done++;
        if (req_drop) n_drop++;
        if (fault && !prev_fault) begin
            fault_seen = 1;
            f_pw_p = pw_p;
            f_pw_c = pw_c;
        end
        prev_pd = prod_drive;
        prev_cd = coin_drive;
        prev_fault = fault;
    endtask

    task automatic do_req(input bit v, input int ch, input int pd, input int cd,
                          input bit inject, input bit rf_in_fault);
        int  cnt, exp_fault, exp_coins, exp_done;
        bit  finished, injected;

        // Reference: walk the payout rules coin by coin
        cnt = model_cnt;
        exp_fault = 0;
        exp_coins = 0;
        if (v && pd >= TIMEOUT) begin
            exp_fault = 1;
        end else begin
            for (int i = 0; i < ch; i++) begin
                if (cnt == 0) begin exp_fault = 3; break; end
                exp_coins++;
                if (cd >= TIMEOUT) begin exp_fault = 2; break; end
                cnt--;
            end
        end
        exp_done = (exp_fault == 0) ? 1 : 0;

        prod_d = pd; coin_d = cd;
        exp_gap = cd + 1 + GAP_CYC + 1;
        pw_p = -1; pw_c = -1;
        prod_sense = 0; coin_sense = 0;
        have_prev_coin = 0;
        n_prod = 0; n_coin = 0; n_done = 0; n_drop = 0;
        fault_seen = 0;

        vend = v; change = 2'(ch);
        @(posedge clk); #1;
        vend = 0; change = 2'd0;
        finished = 0; injected = 0;
        for (int i = 0; i < 300 && !finished; i++) begin
            if (inject && i == 2) begin vend = 1; injected = 1; end
            cycle();
            vend = 0;
            if (i == 0 && v) check("prod_start", int'(prod_drive), 1);
            if (n_done > 0 || fault_seen) finished = 1;
        end
        check("req_finished", int'(finished), 1);
        check("done_count", n_done, exp_done);
        check("prod_pulses", n_prod, int'(v));
        check("coin_pulses", n_coin, exp_coins);
        check("req_drop_count", n_drop, int'(injected));
        check("fault", int'(fault), (exp_fault != 0) ? 1 : 0);
        check("fault_code", int'(fault_code), exp_fault);
        if (exp_fault == 1) check("prod_timeout_cycles", f_pw_p, TIMEOUT);
        if (exp_fault == 2) check("coin_timeout_cycles", f_pw_c, TIMEOUT);
        model_cnt = cnt;
        check("coin_count", int'(coin_count), model_cnt);
        check("coin_low", int'(coin_low), (model_cnt < LOW_THRESH) ? 1 : 0);

        if (exp_fault != 0) begin
            if (rf_in_fault) begin
                refill = 1; @(posedge clk); #1; refill = 0;
                model_cnt = COIN_CAP;
                check("refill_in_fault_count", int'(coin_count), COIN_CAP);
                check("refill_in_fault_low", int'(coin_low), 0);
            end
            clr_fault = 1; @(posedge clk); #1; clr_fault = 0;
            cycle();
            check("clr_busy", int'(busy), 0);
            check("clr_fault_flag", int'(fault), 0);
            check("clr_fault_code", int'(fault_code), 0);
        end else begin
            cycle();
            check("idle_after_done", int'(busy), 0);
        end
    endtask

    task automatic do_refill();
        refill = 1; @(posedge clk); #1; refill = 0;
        model_cnt = COIN_CAP;
        cycle();
        check("refill_count", int'(coin_count), COIN_CAP);
    endtask

    initial begin
        int v, ch, pd, cd, k;
        bit inj;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_busy", int'(busy), 0);
        check("rst_prod_drive", int'(prod_drive), 0);
        check("rst_coin_drive", int'(coin_drive), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_fault_code", int'(fault_code), 0);
        check("rst_coin_count", int'(coin_count), COIN_CAP);
        check("rst_coin_low", int'(coin_low), 0);
        check("rst_req_drop", int'(req_drop), 0);

        do_req(1, 0, 3, 0, 0, 0);
        do_req(1, 2, 0, 0, 0, 0);
        do_refill();
        do_req(0, 1, 0, 1, 0, 0);
        do_req(1, 1, TIMEOUT + 4, 0, 0, 0);
        do_req(0, 2, 0, TIMEOUT + 2, 0, 0);
        do_req(1, 3, 1, 2, 1, 0);
        do_req(0, 3, 0, TIMEOUT - 1, 1, 0);

        for (int r = 0; r < 25; r++) begin
            v  = $urandom_range(0, 1);
            ch = $urandom_range(0, 3);
            if (v == 0 && ch == 0) ch = 1;
            pd = ($urandom_range(0, 7) == 0) ? TIMEOUT + $urandom_range(0, 3)
                                             : $urandom_range(0, TIMEOUT - 1);
            cd = ($urandom_range(0, 7) == 0) ? TIMEOUT + $urandom_range(0, 3)
                                             : $urandom_range(0, TIMEOUT - 1);
            inj = ($urandom_range(0, 3) == 0);
            if (model_cnt < 20 && $urandom_range(0, 3) == 0) do_refill();
            do_req(v[0], ch, pd, cd, inj, 0);
        end

        while (model_cnt > 0) do_req(0, (model_cnt >= 3) ? 3 : model_cnt, 0, 0, 0, 0);
        do_req(0, 1, 0, 0, 0, 1);

        do_req(0, 1, 0, 0, 0, 0);
        change = 2'd2; @(posedge clk); #1; change = 2'd0;
        k = 0;
        while (!coin_drive && k < 20) begin cycle(); k++; end
        check("pre_rst_coin_drive", int'(coin_drive), 1);
        mon_en = 0;
        rst = 1; @(posedge clk); #1; rst = 0;
        check("mid_rst_coin_drive", int'(coin_drive), 0);
        check("mid_rst_coin_count", int'(coin_count), COIN_CAP);
        check("mid_rst_busy", int'(busy), 0);
        model_cnt = COIN_CAP;
        cycle();
        mon_en = 1;
        do_req(1, 1, 2, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
